// File: rtl/iob_eth_tx_frontend.sv
// rtl/iob_eth_tx_frontend.sv - MII nibble transmitter: preamble/SFD, buffered payload, optional FCS (IOB_ETH_TX_CRC_EN), IFG
module iob_eth_tx_frontend #(
    parameter int BUF_ADDR_W = 9,
    parameter int LEN_W      = 11
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  start_i,
    input  logic [LEN_W-1:0]      frame_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  buf_ren_o,
    output logic [BUF_ADDR_W-1:0] buf_addr_o,
    input  logic [31:0]           buf_rdata_i,
    output logic [3:0]            mii_txd_o,
    output logic                  mii_tx_en_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_DATA,
`ifdef IOB_ETH_TX_CRC_EN
        S_CRC,
`endif
        S_IFG
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [LEN_W:0]        dcnt_q, dcnt_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ren_q, ren_d;
    logic                  rvalid_q, rvalid_d;
    logic [BUF_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           word_q, word_d;
    logic [31:0]           nxt_q, nxt_d;

    logic [LEN_W:0]        last_idx;
    logic [LEN_W:0]        word_end;
    logic                  more_words;
    logic [31:0]           nxt_word;
    logic [3:0]            data_nib;

`ifdef IOB_ETH_TX_CRC_EN
    logic [31:0]           crc_q, crc_d;
    logic [31:0]           fcs;

    // Reflected CRC-32 advanced by one nibble, least significant bit first.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int i = 0; i < 4; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs = ~crc_q;
`endif

    // Index of the final payload nibble and end-of-current-word byte position.
    assign last_idx   = {len_q, 1'b0} - {{LEN_W{1'b0}}, 1'b1};
    assign word_end   = {1'b0, dcnt_q[LEN_W:3], 2'b00} + (LEN_W+1)'(4);
    assign more_words = word_end < {1'b0, len_q};
    // A read return arriving this cycle bypasses the staging register.
    assign nxt_word   = rvalid_q ? buf_rdata_i : nxt_q;
    assign data_nib   = word_q[{dcnt_q[2:0], 2'b00} +: 4];

    // Next-state logic: everything advances on cke_i except pulses and read returns.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        len_d    = len_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ren_d    = 1'b0;
        rvalid_d = ren_q;
        addr_d   = addr_q;
        word_d   = word_q;
        nxt_d    = nxt_word;
`ifdef IOB_ETH_TX_CRC_EN
        crc_d    = crc_q;
`endif
        if (cke_i) begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (frame_len_i != '0) begin
                            state_d = S_PRE;
                            len_d   = frame_len_i;
                            cnt_d   = '0;
                            busy_d  = 1'b1;
                            ren_d   = 1'b1;
                            addr_d  = '0;
`ifdef IOB_ETH_TX_CRC_EN
                            crc_d   = 32'hFFFFFFFF;
`endif
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_PRE: begin
                    if (cnt_q == 5'd14) begin
                        state_d = S_SFD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                S_SFD: begin
                    state_d = S_DATA;
                    dcnt_d  = '0;
                    word_d  = nxt_word;
                end
                S_DATA: begin
`ifdef IOB_ETH_TX_CRC_EN
                    crc_d = crc_nib(crc_q, data_nib);
`endif
                    if (dcnt_q == last_idx) begin
`ifdef IOB_ETH_TX_CRC_EN
                        state_d = S_CRC;
`else
                        state_d = S_IFG;
`endif
                        cnt_d = '0;
                    end else begin
                        dcnt_d = dcnt_q + (LEN_W+1)'(1);
                        if (dcnt_q[2:0] == 3'd5 && more_words) begin
                            ren_d  = 1'b1;
                            addr_d = addr_q + {{(BUF_ADDR_W-1){1'b0}}, 1'b1};
                        end
                        if (dcnt_q[2:0] == 3'd7) begin
                            word_d = nxt_word;
                        end
                    end
                end
`ifdef IOB_ETH_TX_CRC_EN
                S_CRC: begin
                    if (cnt_q == 5'd7) begin
                        state_d = S_IFG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
`endif
                S_IFG: begin
                    if (cnt_q == 5'd23) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            len_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ren_q    <= 1'b0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            word_q   <= '0;
            nxt_q    <= '0;
`ifdef IOB_ETH_TX_CRC_EN
            crc_q    <= 32'hFFFFFFFF;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            len_q    <= len_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ren_q    <= ren_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            nxt_q    <= nxt_d;
`ifdef IOB_ETH_TX_CRC_EN
            crc_q    <= crc_d;
`endif
        end
    end

    // MII nibble and enable decoded from the registered state.
    always_comb begin
        mii_tx_en_o = 1'b0;
        mii_txd_o   = 4'h0;
        case (state_q)
            S_PRE: begin
                mii_tx_en_o = 1'b1;
                mii_txd_o   = 4'h5;
            end
            S_SFD: begin
                mii_tx_en_o = 1'b1;
                mii_txd_o   = 4'hD;
            end
            S_DATA: begin
                mii_tx_en_o = 1'b1;
                mii_txd_o   = data_nib;
            end
`ifdef IOB_ETH_TX_CRC_EN
            S_CRC: begin
                mii_tx_en_o = 1'b1;
                mii_txd_o   = fcs[{cnt_q[2:0], 2'b00} +: 4];
            end
`endif
            default: begin
                mii_tx_en_o = 1'b0;
                mii_txd_o   = 4'h0;
            end
        endcase
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign buf_ren_o  = ren_q;
    assign buf_addr_o = addr_q;

endmodule

// File: tb/tb_iob_eth_tx_frontend.sv
// tb/tb_iob_eth_tx_frontend.sv - self-checking bench for iob_eth_tx_frontend
module tb_iob_eth_tx_frontend;

    localparam int AW = 9;
    localparam int LW = 11;
`ifdef IOB_ETH_TX_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst_n;
    logic          cke;
    logic          start;
    logic [LW-1:0] frame_len;
    logic          busy;
    logic          done;
    logic          ren;
    logic [AW-1:0] addr;
    logic [31:0]   rdata;
    logic [3:0]    txd;
    logic          txen;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:511];
    logic [4:0]  exp_q[$];
    logic [3:0]  obs_q[$];

    iob_eth_tx_frontend #(.BUF_ADDR_W(AW), .LEN_W(LW)) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .cke_i       (cke),
        .start_i     (start),
        .frame_len_i (frame_len),
        .busy_o      (busy),
        .done_o      (done),
        .buf_ren_o   (ren),
        .buf_addr_o  (addr),
        .buf_rdata_i (rdata),
        .mii_txd_o   (txd),
        .mii_tx_en_o (txen)
    );

    always #5 clk = ~clk;

    // Buffer model: data valid only in the cycle after a read, garbage otherwise.
    always @(posedge clk) rdata <= ren ? mem[addr] : $urandom();

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected tx_en=1 nibble stream: preamble, SFD, payload bytes, optional FCS.
    task automatic build_exp(input int len);
        logic [31:0] crc, w, fcs;
        logic [7:0]  byt;
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back(5'h15);
        exp_q.push_back(5'h1D);
        crc = 32'hFFFFFFFF;
        for (int b = 0; b < len; b++) begin
            w   = mem[b / 4];
            byt = 8'(w >> (8 * (b % 4)));
            exp_q.push_back({1'b1, byt[3:0]});
            exp_q.push_back({1'b1, byt[7:4]});
            crc = crc ^ {24'd0, byt};
            for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
        end
        if (CRC_EN) begin
            fcs = ~crc;
            for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, fcs[4*k +: 4]});
        end
    endtask

    // Sends one frame; m=2 toggles cke every cycle; extra issues a start mid-frame.
    task automatic run_frame(input string tag, input int len, input int m, input bit extra);
        int f, lim, bad, dones, encnt, reads, addr_bad, nwords, e;
        logic [6:0] o, x;
        build_exp(len);
        f = exp_q.size();
        nwords = (len + 3) / 4;
        lim = m * (f + 24) + 2 * m + 2;
        bad = 0; dones = 0; encnt = 0; reads = 0; addr_bad = 0;
        obs_q.delete();
        cke = 1'b1; start = 1'b1; frame_len = LW'(len);
        @(posedge clk);
        #1 start = 1'b0;
        cke = (m == 1);
        for (int k = 0; k < lim; k++) begin
            @(negedge clk);
            o = {busy, done, txen, txd};
            if (k < m * (f + 24)) begin
                e = k / m;
                x = (e < f) ? {2'b10, exp_q[e]} : 7'b1000000;
            end else if (k == m * (f + 24)) begin
                x = 7'b0100000;
            end else begin
                x = 7'b0000000;
            end
            if (o !== x) bad++;
            if ((k % m) == 0 && txen === 1'b1) obs_q.push_back(txd);
            if (done === 1'b1) dones++;
            if (txen === 1'b1) encnt++;
            if (ren === 1'b1) begin
                reads++;
                if (int'(addr) > nwords - 1) addr_bad++;
            end
            cke = (((k + 1) % m) == 0);
            if (extra) begin
                start = (k == 40);
                frame_len = (k == 40) ? LW'(3) : LW'(len);
            end
        end
        start = 1'b0;
        chk({tag, "_trace_mismatches"}, 64'(bad), 64'd0);
        chk({tag, "_done_pulses"}, 64'(dones), 64'd1);
        chk({tag, "_txen_cycles"}, 64'(encnt), 64'(m * f));
        chk({tag, "_reads"}, 64'(reads), 64'(nwords));
        chk({tag, "_addr_overrange"}, 64'(addr_bad), 64'd0);
    endtask

    initial begin
        logic [3:0] n27 [8];
        logic [3:0] n29 [10];
        logic [3:0] n28 [8];
        int dones, encnt, busycnt, first_done;

        n27 = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0};
        n29 = '{4'hA, 4'hA, 4'hB, 4'hB, 4'hC, 4'hC, 4'hD, 4'hD, 4'h1, 4'h1};
        n28 = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
        for (int i = 0; i < 512; i++) mem[i] = $urandom();

        // Reset state
        arst_n = 1'b0; cke = 1'b0; start = 1'b0; frame_len = '0;
        #2;
        chk("reset_outputs", {busy, done, ren, addr, txen, txd}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 arst_n = 1'b1;
        @(negedge clk);

        // Basic 4-byte frame
        mem[0] = 32'h04030201;
        run_frame("len4", 4, 1, 1'b0);
        for (int i = 0; i < 8; i++) chk($sformatf("len4_nib%0d", i), 64'(obs_q[16 + i]), 64'(n27[i]));

        // Same frame with cke toggling
        run_frame("len4_cke2", 4, 2, 1'b0);
        for (int i = 0; i < 8; i++) chk($sformatf("len4_cke2_nib%0d", i), 64'(obs_q[16 + i]), 64'(n27[i]));

        // Partial last word
        mem[0] = 32'hDDCCBBAA; mem[1] = 32'h00000011;
        run_frame("len5", 5, 1, 1'b0);
        for (int i = 0; i < 10; i++) chk($sformatf("len5_nib%0d", i), 64'(obs_q[16 + i]), 64'(n29[i]));

`ifdef IOB_ETH_TX_CRC_EN
        mem[0] = 32'h34333231; mem[1] = 32'h38373635; mem[2] = 32'h00000039;
        run_frame("crc9", 9, 1, 1'b0);
        for (int i = 0; i < 8; i++) chk($sformatf("crc9_fcs%0d", i), 64'(obs_q[34 + i]), 64'(n28[i]));
`endif

        // Ignored start during a busy frame
        mem[0] = 32'h04030201;
        run_frame("busy_start", 4, 1, 1'b1);

        // Zero-length request
        cke = 1'b1; start = 1'b1; frame_len = '0;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0; encnt = 0; busycnt = 0; first_done = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = k;
            end
            if (txen === 1'b1) encnt++;
            if (busy === 1'b1) busycnt++;
        end
        chk("len0_done_pulses", 64'(dones), 64'd1);
        chk("len0_done_cycle", 64'(first_done), 64'd0);
        chk("len0_txen", 64'(encnt), 64'd0);
        chk("len0_busy", 64'(busycnt), 64'd0);

        // Reset in the middle of DATA
        mem[0] = $urandom(); mem[1] = $urandom();
        cke = 1'b1; start = 1'b1; frame_len = LW'(8);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_txen", 64'(txen), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, ren, addr, txen, txd}, 64'd0);
        @(posedge clk);
        #1;
        chk("midreset_held", {busy, done, ren, addr, txen, txd}, 64'd0);
        arst_n = 1'b1;
        @(negedge clk);
        mem[0] = 32'h04030201;
        run_frame("after_reset", 4, 1, 1'b0);
        for (int i = 0; i < 8; i++) chk($sformatf("after_reset_nib%0d", i), 64'(obs_q[16 + i]), 64'(n27[i]));

        // Boundary lengths and randomized frames
        for (int i = 0; i < 8; i++) mem[i] = $urandom();
        run_frame("len1_cke2", 1, 2, 1'b0);
        run_frame("len8", 8, 1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            int len, m;
            len = $urandom_range(1, 24);
            m = $urandom_range(1, 2);
            for (int i = 0; i < 8; i++) mem[i] = $urandom();
            run_frame($sformatf("rand%0d", r), len, m, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
